// File: rtl/zacore_pkg.sv
// Shared types and constants for the zacore memory arbiter: FSM state,
// transaction owner, bus widths and the latched memory command.
package zacore_pkg;

    localparam int XLEN    = 32;
    localparam int WMASK_W = 4;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    typedef struct packed {
        logic               we;
        logic [XLEN-1:0]    addr;
        logic [XLEN-1:0]    wdata;
        logic [WMASK_W-1:0] wmask;
    } mem_cmd_t;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] lim);
        logic [CNT_W-1:0] res;
        if (cnt >= lim) begin
            res = lim;
        end else begin
            res = cnt + CNT_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/zacore_mem_arb_prio.sv
// Requester selection for the memory arbiter: data has priority, but fetch
// is forced through once it has been passed over STARVE_LIMIT times in a row.
module zacore_mem_arb_prio
    import zacore_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_grant_en,
    input  logic i_fetch_req,
    input  logic i_data_req,
    output logic o_fetch_gnt,
    output logic o_data_gnt
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             fetch_forced_s;

    assign fetch_forced_s = i_fetch_req && (starve_q == LIMIT);

    // Grant selection and starvation-count update.
    always_comb begin
        o_fetch_gnt = 1'b0;
        o_data_gnt  = 1'b0;
        starve_d    = starve_q;
        if (i_grant_en) begin
            if (i_data_req && !fetch_forced_s) begin
                o_data_gnt = 1'b1;
            end else if (i_fetch_req) begin
                o_fetch_gnt = 1'b1;
            end else begin
                o_data_gnt = 1'b0;
            end
        end else begin
            o_fetch_gnt = 1'b0;
        end

        if (o_data_gnt) begin
            if (i_fetch_req) begin
                starve_d = sat_inc(starve_q, LIMIT);
            end else begin
                starve_d = '0;
            end
        end else if (o_fetch_gnt) begin
            starve_d = '0;
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/zacore_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port with one
// transaction outstanding; latches the winner's command and routes the response.
module zacore_mem_arbiter
    import zacore_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_fetch_req,
    input  logic [XLEN-1:0]    i_fetch_addr,
    output logic               o_fetch_gnt,
    output logic               o_fetch_rvalid,
    output logic [XLEN-1:0]    o_fetch_rdata,
    input  logic               i_data_req,
    input  logic               i_data_we,
    input  logic [XLEN-1:0]    i_data_addr,
    input  logic [XLEN-1:0]    i_data_wdata,
    input  logic [WMASK_W-1:0] i_data_wmask,
    output logic               o_data_gnt,
    output logic               o_data_rvalid,
    output logic [XLEN-1:0]    o_data_rdata,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [XLEN-1:0]    o_mem_addr,
    output logic [XLEN-1:0]    o_mem_wdata,
    output logic [WMASK_W-1:0] o_mem_wmask,
    input  logic               i_mem_ready,
    input  logic               i_mem_rvalid,
    input  logic [XLEN-1:0]    i_mem_rdata,
    output logic               o_proto_err
);

    arb_state_e      state_q, state_d;
    owner_e          owner_q, owner_d;
    mem_cmd_t        cmd_q, cmd_d;
    logic            fetch_rvalid_q, fetch_rvalid_d;
    logic            data_rvalid_q, data_rvalid_d;
    logic [XLEN-1:0] fetch_rdata_q, fetch_rdata_d;
    logic [XLEN-1:0] data_rdata_q, data_rdata_d;
    logic            proto_err_q, proto_err_d;
    logic            grant_en_s;
    logic            fetch_gnt_s;
    logic            data_gnt_s;

    // Reset is folded in so grants read 0 while the block is held in reset.
    assign grant_en_s = (state_q == ST_IDLE) && i_rst_n;

    zacore_mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_grant_en  (grant_en_s),
        .i_fetch_req (i_fetch_req),
        .i_data_req  (i_data_req),
        .o_fetch_gnt (fetch_gnt_s),
        .o_data_gnt  (data_gnt_s)
    );

    // FSM next state, command latch and response routing.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        cmd_d          = cmd_q;
        fetch_rvalid_d = 1'b0;
        data_rvalid_d  = 1'b0;
        fetch_rdata_d  = fetch_rdata_q;
        data_rdata_d   = data_rdata_q;
        proto_err_d    = proto_err_q | (i_mem_rvalid && (state_q != ST_WAIT_RESP));

        case (state_q)
            ST_IDLE: begin
                if (data_gnt_s) begin
                    owner_d = OWN_DATA;
                    cmd_d   = '{we: i_data_we, addr: i_data_addr,
                                wdata: i_data_wdata, wmask: i_data_wmask};
                    state_d = ST_ISSUE;
                end else if (fetch_gnt_s) begin
                    owner_d = OWN_FETCH;
                    cmd_d   = '{we: 1'b0, addr: i_fetch_addr,
                                wdata: {XLEN{1'b0}}, wmask: {WMASK_W{1'b0}}};
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (i_mem_ready) begin
                    // Stores have no read response; completion is signalled here.
                    if ((owner_q == OWN_DATA) && cmd_q.we) begin
                        data_rvalid_d = 1'b1;
                        data_rdata_d  = {XLEN{1'b0}};
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_RESP;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_RESP: begin
                if (i_mem_rvalid) begin
                    if (owner_q == OWN_FETCH) begin
                        fetch_rvalid_d = 1'b1;
                        fetch_rdata_d  = i_mem_rdata;
                    end else begin
                        data_rvalid_d = 1'b1;
                        data_rdata_d  = i_mem_rdata;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWN_FETCH;
            cmd_q          <= '0;
            fetch_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
            fetch_rdata_q  <= {XLEN{1'b0}};
            data_rdata_q   <= {XLEN{1'b0}};
            proto_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            cmd_q          <= cmd_d;
            fetch_rvalid_q <= fetch_rvalid_d;
            data_rvalid_q  <= data_rvalid_d;
            fetch_rdata_q  <= fetch_rdata_d;
            data_rdata_q   <= data_rdata_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign o_fetch_gnt    = fetch_gnt_s;
    assign o_data_gnt     = data_gnt_s;
    assign o_fetch_rvalid = fetch_rvalid_q;
    assign o_fetch_rdata  = fetch_rdata_q;
    assign o_data_rvalid  = data_rvalid_q;
    assign o_data_rdata   = data_rdata_q;
    assign o_mem_req      = (state_q == ST_ISSUE);
    assign o_mem_we       = cmd_q.we;
    assign o_mem_addr     = cmd_q.addr;
    assign o_mem_wdata    = cmd_q.wdata;
    assign o_mem_wmask    = cmd_q.wmask;
    assign o_proto_err    = proto_err_q;

endmodule

// File: tb/tb_zacore_mem_arbiter.sv
// Directed bench for zacore_mem_arbiter: a table of single transactions plus
// hand-written sequences for starvation, stray responses and reset mid-read.
module tb_zacore_mem_arbiter;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_fetch_req;
    logic [31:0] i_fetch_addr;
    logic        o_fetch_gnt;
    logic        o_fetch_rvalid;
    logic [31:0] o_fetch_rdata;
    logic        i_data_req;
    logic        i_data_we;
    logic [31:0] i_data_addr;
    logic [31:0] i_data_wdata;
    logic [3:0]  i_data_wmask;
    logic        o_data_gnt;
    logic        o_data_rvalid;
    logic [31:0] o_data_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_proto_err;

    int n_vec = 0;
    int n_err = 0;

    zacore_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_fetch_req    (i_fetch_req),
        .i_fetch_addr   (i_fetch_addr),
        .o_fetch_gnt    (o_fetch_gnt),
        .o_fetch_rvalid (o_fetch_rvalid),
        .o_fetch_rdata  (o_fetch_rdata),
        .i_data_req     (i_data_req),
        .i_data_we      (i_data_we),
        .i_data_addr    (i_data_addr),
        .i_data_wdata   (i_data_wdata),
        .i_data_wmask   (i_data_wmask),
        .o_data_gnt     (o_data_gnt),
        .o_data_rvalid  (o_data_rvalid),
        .o_data_rdata   (o_data_rdata),
        .o_mem_req      (o_mem_req),
        .o_mem_we       (o_mem_we),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_wmask    (o_mem_wmask),
        .i_mem_ready    (i_mem_ready),
        .i_mem_rvalid   (i_mem_rvalid),
        .i_mem_rdata    (i_mem_rdata),
        .o_proto_err    (o_proto_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          rd;        // cycles of ready low before accept
        int          rs;        // cycles from accept to mem rvalid (>=1)
        logic [31:0] mem_rdata;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_fetch_req  = 1'b0;
        i_data_req   = 1'b0;
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'h0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_fgnt"}, {31'd0, o_fetch_gnt}, 32'd0);
        chk({nm, "_dgnt"}, {31'd0, o_data_gnt}, 32'd0);
        chk({nm, "_rv"}, {30'd0, o_fetch_rvalid, o_data_rvalid}, 32'd0);
        chk({nm, "_rdata"}, o_fetch_rdata | o_data_rdata, 32'd0);
        chk({nm, "_memreq"}, {31'd0, o_mem_req}, 32'd0);
        chk({nm, "_memaddr"}, o_mem_addr, 32'd0);
        chk({nm, "_memfld"}, {o_mem_wdata[30:0], o_mem_we} | {28'd0, o_mem_wmask}, 32'd0);
        chk({nm, "_perr"}, {31'd0, o_proto_err}, 32'd0);
    endtask

    // Runs one transaction from a table entry; entered and left just after a rising edge.
    task automatic run_vec(input vec_t v);
        logic got;
        i_fetch_req  = !v.is_data;
        i_data_req   = v.is_data;
        i_data_we    = v.is_data ? v.we : 1'b1;
        i_fetch_addr = v.is_data ? 32'hFFFF_FFF0 : v.addr;
        i_data_addr  = v.is_data ? v.addr : 32'hFFFF_FFF0;
        i_data_wdata = v.is_data ? v.wdata : 32'hFFFF_FFFF;
        i_data_wmask = v.is_data ? v.wmask : 4'hF;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge i_clk);
            if (o_fetch_gnt || o_data_gnt) got = 1'b1;
            else tick();
        end
        chk("gnt_seen", {31'd0, got}, 32'd1);
        chk("fetch_gnt", {31'd0, o_fetch_gnt}, {31'd0, !v.is_data});
        chk("data_gnt", {31'd0, o_data_gnt}, {31'd0, v.is_data});
        tick();
        i_fetch_req = 1'b0;
        i_data_req  = 1'b0;
        for (int k = 0; k <= v.rd; k++) begin
            i_mem_ready = (k == v.rd);
            @(negedge i_clk);
            chk("mem_req", {31'd0, o_mem_req}, 32'd1);
            chk("mem_we", {31'd0, o_mem_we}, {31'd0, v.exp_we});
            chk("mem_addr", o_mem_addr, v.addr);
            chk("mem_wdata", o_mem_wdata, v.exp_wdata);
            chk("mem_wmask", {28'd0, o_mem_wmask}, {28'd0, v.exp_wmask});
            tick();
        end
        i_mem_ready = 1'b0;
        if (!(v.is_data && v.we)) begin
            for (int j = 0; j < v.rs; j++) begin
                i_mem_rvalid = (j == v.rs - 1);
                i_mem_rdata  = (j == v.rs - 1) ? v.mem_rdata : 32'h0BAD_0BAD;
                @(negedge i_clk);
                chk("wait_memreq", {31'd0, o_mem_req}, 32'd0);
                chk("early_rvalid", {30'd0, o_fetch_rvalid, o_data_rvalid}, 32'd0);
                tick();
            end
            i_mem_rvalid = 1'b0;
        end
        @(negedge i_clk);
        chk("fetch_rvalid", {31'd0, o_fetch_rvalid}, {31'd0, !v.is_data});
        chk("data_rvalid", {31'd0, o_data_rvalid}, {31'd0, v.is_data});
        chk("rdata", v.is_data ? o_data_rdata : o_fetch_rdata, v.exp_rdata);
        tick();
        @(negedge i_clk);
        chk("rvalid_pulse", {30'd0, o_fetch_rvalid, o_data_rvalid}, 32'd0);
        tick();
    endtask

    initial begin
        logic got;
        logic prev_fetch;
        int   wait_c;

        //        data we    addr           wdata          wmask rd rs mem_rdata      exp_we exp_wdata     exp_wmask exp_rdata
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 0, 1, 32'hDEAD_BEEF, 1'b0, 32'h0,        4'h0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1122_3344, 4'h5, 2, 1, 32'h0,         1'b1, 32'h1122_3344, 4'h5, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0203, 32'h0,         4'h0, 1, 3, 32'hCAFE_F00D, 1'b0, 32'h0,        4'h0, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 32'h0001_0001, 32'h0,         4'h0, 0, 2, 32'h1234_5678, 1'b0, 32'h0,        4'h0, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFE, 32'hA5A5_A5A5, 4'hF, 0, 1, 32'h0,         1'b1, 32'hA5A5_A5A5, 4'hF, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0003, 32'h0,         4'h0, 3, 1, 32'h8000_0001, 1'b0, 32'h0,        4'h0, 32'h8000_0001};

        i_rst_n      = 1'b0;
        idle_inputs();
        i_fetch_addr = 32'h0;
        i_data_we    = 1'b0;
        i_data_addr  = 32'h0;
        i_data_wdata = 32'h0;
        i_data_wmask = 4'h0;

        // Reset state, with both requests asserted to prove grants are held off.
        tick();
        i_fetch_req = 1'b1;
        i_data_req  = 1'b1;
        @(negedge i_clk);
        chk_all_zero("reset");
        tick();
        idle_inputs();
        i_rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Starvation: both request continuously, stores and fetches complete at once.
        i_rst_n = 1'b0;
        tick();
        i_rst_n      = 1'b1;
        i_fetch_req  = 1'b1;
        i_fetch_addr = 32'h0000_0400;
        i_data_req   = 1'b1;
        i_data_we    = 1'b1;
        i_data_addr  = 32'h0000_0300;
        i_data_wdata = 32'h0000_0055;
        i_data_wmask = 4'hF;
        prev_fetch   = 1'b0;
        for (int g = 0; g < 10; g++) begin
            got    = 1'b0;
            wait_c = 0;
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge i_clk);
                if (o_fetch_gnt || o_data_gnt) got = 1'b1;
                else begin
                    wait_c++;
                    tick();
                end
            end
            chk("starve_gnt_seen", {31'd0, got}, 32'd1);
            chk("starve_order", {30'd0, o_fetch_gnt, o_data_gnt}, ((g % 5) == 4) ? 32'd2 : 32'd1);
            if (g > 0) chk("b2b_wait", wait_c, 32'd0);
            if (prev_fetch) begin
                chk("b2b_rvalid", {31'd0, o_fetch_rvalid}, 32'd1);
                chk("b2b_rdata", o_fetch_rdata, 32'hF00D_0000 + g - 1);
            end
            prev_fetch = o_fetch_gnt;
            tick();
            i_mem_ready = 1'b1;
            @(negedge i_clk);
            chk("starve_memreq", {31'd0, o_mem_req}, 32'd1);
            chk("starve_memaddr", o_mem_addr, prev_fetch ? 32'h0000_0400 : 32'h0000_0300);
            tick();
            i_mem_ready = 1'b0;
            if (prev_fetch) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = 32'hF00D_0000 + g;
                @(negedge i_clk);
                tick();
                i_mem_rvalid = 1'b0;
            end
        end
        idle_inputs();
        @(negedge i_clk);
        chk("starve_last_rdata", o_fetch_rdata, 32'hF00D_0009);
        tick();

        // Stray response in IDLE: sticky error, traffic unaffected.
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h7777_7777;
        @(negedge i_clk);
        chk("perr_pre", {31'd0, o_proto_err}, 32'd0);
        tick();
        i_mem_rvalid = 1'b0;
        @(negedge i_clk);
        chk("perr_set", {31'd0, o_proto_err}, 32'd1);
        tick();
        run_vec(vecs[1]);
        run_vec(vecs[0]);
        @(negedge i_clk);
        chk("perr_sticky", {31'd0, o_proto_err}, 32'd1);
        tick();

        // Reset asserted while a fetch waits for its response.
        i_fetch_req  = 1'b1;
        i_fetch_addr = 32'h0000_0500;
        @(negedge i_clk);
        chk("rst_fetch_gnt", {31'd0, o_fetch_gnt}, 32'd1);
        tick();
        i_fetch_req = 1'b0;
        i_mem_ready = 1'b1;
        tick();
        i_mem_ready = 1'b0;
        @(negedge i_clk);
        chk("rst_pre_addr", o_mem_addr, 32'h0000_0500);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("rst_wait");
        tick();
        i_rst_n = 1'b1;
        // Late response for the abandoned read.
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h5555_AAAA;
        tick();
        i_mem_rvalid = 1'b0;
        @(negedge i_clk);
        chk("late_rvalid_perr", {31'd0, o_proto_err}, 32'd1);
        chk("late_rvalid_none", {30'd0, o_fetch_rvalid, o_data_rvalid}, 32'd0);
        tick();
        run_vec(vecs[3]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
